// File: rtl/pclk_pkg.sv
// Shared types for the four-phase stepwise power-clock generator.
package pclk_pkg;

    localparam int unsigned NUM_PHASES = 4;

    typedef enum logic [1:0] {
        PhWait   = 2'd0,
        PhRampUp = 2'd1,
        PhHold   = 2'd2,
        PhRampDn = 2'd3
    } phase_st_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } ctrl_st_e;

    // Phase k runs one quarter behind phase k-1.
    function automatic phase_st_e nominal_state(input logic [1:0] q, input logic [1:0] k);
        logic [1:0] rel;
        phase_st_e  st;
        rel = q - k;
        unique case (rel)
            2'd0:    st = PhRampUp;
            2'd1:    st = PhHold;
            2'd2:    st = PhRampDn;
            default: st = PhWait;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/pclk_phase_lane.sv
// One power-clock phase: arm flag plus registered quarter state and level codes.
module pclk_phase_lane
    import pclk_pkg::*;
#(
    parameter int unsigned STEPS = 4,
    parameter int unsigned LVL_W = $clog2(STEPS + 1),
    parameter int unsigned K     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_nxt,
    input  logic             drain_nxt,
    input  logic [LVL_W-1:0] step_nxt,
    input  logic [1:0]       q_nxt,
    output logic             armed,
    output logic [1:0]       st,
    output logic [LVL_W-1:0] pos_lvl,
    output logic [LVL_W-1:0] neg_lvl
);

    localparam logic [LVL_W-1:0] StepsLvl = LVL_W'(STEPS);

    phase_st_e        nom, st_d, st_q;
    logic             arm_d, arm_q;
    logic [LVL_W-1:0] lvl_d, pos_q, neg_q;

    always_comb begin
        nom   = nominal_state(q_nxt, 2'(K));
        arm_d = arm_q;
        if (run_nxt) begin
            if (nom == PhRampUp && step_nxt == '0) arm_d = 1'b1;
        end else if (drain_nxt) begin
            // While draining, no new ramp starts and finished phases drop out.
            if (nom == PhRampUp || nom == PhWait) arm_d = 1'b0;
        end else begin
            arm_d = 1'b0;
        end

        st_d  = arm_d ? nom : PhWait;
        lvl_d = '0;
        unique case (st_d)
            PhRampUp: lvl_d = step_nxt + 1'b1;
            PhHold:   lvl_d = StepsLvl;
            PhRampDn: lvl_d = StepsLvl - 1'b1 - step_nxt;
            default:  lvl_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arm_q <= 1'b0;
            st_q  <= PhWait;
            pos_q <= '0;
            neg_q <= StepsLvl;
        end else begin
            arm_q <= arm_d;
            st_q  <= st_d;
            pos_q <= lvl_d;
            neg_q <= StepsLvl - lvl_d;
        end
    end

    assign armed   = arm_q;
    assign st      = st_q;
    assign pos_lvl = pos_q;
    assign neg_lvl = neg_q;

endmodule

// File: rtl/pclk_phase_gen.sv
// Four-phase stepwise power-clock generator with graceful stop.
// Define PCLK_CYCLE_CNT_EN to add the 16-bit completed-period counter output cycle_cnt.
module pclk_phase_gen
    import pclk_pkg::*;
#(
    parameter int unsigned STEPS = 4,
    parameter int unsigned LVL_W = $clog2(STEPS + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    output logic [NUM_PHASES*LVL_W-1:0] clkpos_lvl,
    output logic [NUM_PHASES*LVL_W-1:0] clkneg_lvl,
    output logic [2*NUM_PHASES-1:0]     phase_st,
    output logic                        busy
`ifdef PCLK_CYCLE_CNT_EN
    ,
    output logic [15:0]                 cycle_cnt
`endif
);

    localparam logic [LVL_W-1:0] StepLast = LVL_W'(STEPS - 1);

    ctrl_st_e              state_q, state_d;
    logic [LVL_W-1:0]      step_q, step_d;
    logic [1:0]            q_q, q_d;
    logic                  step_wrap, period_end;
    logic                  run_nxt, drain_nxt;
    logic [NUM_PHASES-1:0] armed;

    assign step_wrap  = (step_q == StepLast);
    assign period_end = step_wrap && (q_q == 2'd3);

    always_comb begin
        state_d = state_q;
        step_d  = step_q + 1'b1;
        q_d     = q_q;
        if (step_wrap) begin
            step_d = '0;
            q_d    = q_q + 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                step_d = '0;
                q_d    = '0;
                if (en) state_d = StRun;
            end
            // A stop request only counts when sampled at the period boundary.
            StRun: if (period_end && !en) state_d = StDrain;
            StDrain: begin
                if (step_wrap && q_q == 2'd1) begin
                    state_d = StIdle;
                    step_d  = '0;
                    q_d     = '0;
                end
            end
            default: begin
                state_d = StIdle;
                step_d  = '0;
                q_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            step_q  <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            q_q     <= q_d;
        end
    end

    assign run_nxt   = (state_d == StRun);
    assign drain_nxt = (state_d == StDrain);

    for (genvar k = 0; k < NUM_PHASES; k++) begin : g_lane
        pclk_phase_lane #(
            .STEPS (STEPS),
            .LVL_W (LVL_W),
            .K     (k)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .run_nxt   (run_nxt),
            .drain_nxt (drain_nxt),
            .step_nxt  (step_d),
            .q_nxt     (q_d),
            .armed     (armed[k]),
            .st        (phase_st[2*k +: 2]),
            .pos_lvl   (clkpos_lvl[k*LVL_W +: LVL_W]),
            .neg_lvl   (clkneg_lvl[k*LVL_W +: LVL_W])
        );
    end

    assign busy = |armed;

`ifdef PCLK_CYCLE_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == StRun && period_end) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pclk_phase_gen.sv
// Self-checking bench for pclk_phase_gen (STEPS=4) against a time-index reference model.
module tb_pclk_phase_gen;

    localparam int S  = 4;
    localparam int LW = $clog2(S + 1);
    localparam int NP = 4;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              en    = 1'b0;
    logic [NP*LW-1:0]  clkpos_lvl, clkneg_lvl;
    logic [2*NP-1:0]   phase_st;
    logic              busy;
`ifdef PCLK_CYCLE_CNT_EN
    logic [15:0]       cycle_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model: mode 0 idle / 1 run / 2 drain, m_t = cycle index within the period or drain.
    int m_mode = 0;
    int m_t    = 0;
    int m_cnt  = 0;
    bit m_armed[NP];
    int exp_pos[NP];
    int exp_st[NP];
    bit exp_busy;

    pclk_phase_gen #(.STEPS(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clkpos_lvl (clkpos_lvl),
        .clkneg_lvl (clkneg_lvl),
        .phase_st   (phase_st),
        .busy       (busy)
`ifdef PCLK_CYCLE_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic int act_pos(input int k);
        return int'(clkpos_lvl[k*LW +: LW]);
    endfunction

    function automatic int act_neg(input int k);
        return int'(clkneg_lvl[k*LW +: LW]);
    endfunction

    function automatic int act_st(input int k);
        return int'(phase_st[2*k +: 2]);
    endfunction

    task automatic model_step(input bit r, input bit e);
        int q, i, rel;
        if (!r) begin
            m_mode = 0;
            m_t    = 0;
            m_cnt  = 0;
        end else if (m_mode == 0) begin
            if (e) begin
                m_mode = 1;
                m_t    = 0;
            end
        end else if (m_mode == 1) begin
            if (m_t == 4*S - 1) begin
                m_t   = 0;
                m_cnt = (m_cnt + 1) % 65536;
                if (!e) m_mode = 2;
            end else begin
                m_t++;
            end
        end else begin
            if (m_t == 2*S - 1) begin
                m_mode = 0;
                m_t    = 0;
            end else begin
                m_t++;
            end
        end
        q = m_t / S;
        i = m_t % S;
        exp_busy = 1'b0;
        for (int k = 0; k < NP; k++) begin
            rel = (q - k + 4) % 4;
            if (m_mode == 0) m_armed[k] = 1'b0;
            else if (m_mode == 1 && rel == 0 && i == 0) m_armed[k] = 1'b1;
            else if (m_mode == 2 && (rel == 0 || rel == 3)) m_armed[k] = 1'b0;
            exp_pos[k] = 0;
            exp_st[k]  = 0;
            if (m_armed[k]) begin
                exp_st[k] = (rel + 1) % 4;
                case (rel)
                    0:       exp_pos[k] = i + 1;
                    1:       exp_pos[k] = S;
                    2:       exp_pos[k] = S - 1 - i;
                    default: exp_pos[k] = 0;
                endcase
            end
            exp_busy |= m_armed[k];
        end
    endtask

    task automatic tick(input bit r, input bit e);
        @(negedge clk);
        rst_n = r;
        en    = e;
        @(posedge clk);
        model_step(r, e);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        for (int k = 0; k < NP; k++) begin
            n_tests++;
            if (act_pos(k) !== 0 || act_neg(k) !== S || act_st(k) !== 0) begin
                n_fail++;
                $display("FAIL reset phase%0d got pos=%0d neg=%0d st=%0d want 0/%0d/0",
                         k, act_pos(k), act_neg(k), act_st(k), S);
            end
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset busy got %b want 0", busy);
        end
`ifdef PCLK_CYCLE_CNT_EN
        n_tests++;
        if (cycle_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset cycle_cnt got %0d want 0", cycle_cnt);
        end
`endif
    endtask

    task automatic test_startup();
        int ramp0[16] = '{1, 2, 3, 4, 4, 4, 4, 4, 3, 2, 1, 0, 0, 0, 0, 0};
        for (int c = 0; c < 16; c++) begin
            tick(1'b1, 1'b1);
            n_tests++;
            if (act_pos(0) !== ramp0[c]) begin
                n_fail++;
                $display("FAIL startup pos0 c=%0d got %0d want %0d", c + 1, act_pos(0), ramp0[c]);
            end
            for (int k = 1; k < NP; k++) begin
                if (c <= 4*k) begin
                    n_tests++;
                    if (act_pos(k) !== ((c == 4*k) ? 1 : 0)) begin
                        n_fail++;
                        $display("FAIL startup pos%0d c=%0d got %0d want %0d",
                                 k, c + 1, act_pos(k), (c == 4*k) ? 1 : 0);
                    end
                end
            end
        end
    endtask

    task automatic test_drain();
        int drain3[8] = '{4, 4, 4, 4, 3, 2, 1, 0};
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        for (int j = 1; j < 4*S; j++) begin
            tick(1'b1, j < S);
            for (int k = 0; k < NP; k++) begin
                n_tests++;
                if (act_pos(k) !== exp_pos[k]) begin
                    n_fail++;
                    $display("FAIL drain_run pos%0d t=%0d got %0d want %0d",
                             k, j, act_pos(k), exp_pos[k]);
                end
            end
        end
        // en toggles during drain and must be ignored.
        for (int d = 0; d < 8; d++) begin
            tick(1'b1, d[0]);
            n_tests++;
            if (act_pos(3) !== drain3[d] || act_pos(0) !== 0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL drain d=%0d got pos3=%0d pos0=%0d busy=%b want %0d/0/1",
                         d, act_pos(3), act_pos(0), busy, drain3[d]);
            end
        end
        for (int n = 0; n < 2; n++) begin
            tick(1'b1, 1'b0);
            n_tests++;
            if (busy !== 1'b0 || clkpos_lvl !== '0 || phase_st !== '0) begin
                n_fail++;
                $display("FAIL drain_idle n=%0d got busy=%b pos=%h st=%h want 0/0/0",
                         n, busy, clkpos_lvl, phase_st);
            end
        end
    endtask

    task automatic test_cancel();
        int hist[4*S][NP];
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        for (int j = 1; j < 4*S; j++) tick(1'b1, !(j >= S + 1 && j <= 2*S));
        tick(1'b1, 1'b1);
        n_tests++;
        if (act_pos(0) !== 1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL cancel restart got pos0=%0d busy=%b want 1/1", act_pos(0), busy);
        end
        for (int c = 1; c < 4*S; c++) tick(1'b1, 1'b1);
        for (int c = 0; c < 4*S; c++) begin
            tick(1'b1, 1'b1);
            for (int k = 0; k < NP; k++) begin
                hist[c][k] = act_pos(k);
                n_tests++;
                if (act_pos(k) !== exp_pos[k] || act_pos(k) + act_neg(k) !== S) begin
                    n_fail++;
                    $display("FAIL cancel pos%0d c=%0d got pos=%0d neg=%0d want pos=%0d sum=%0d",
                             k, c, act_pos(k), act_neg(k), exp_pos[k], S);
                end
            end
        end
        for (int c = S; c < 4*S; c++) begin
            for (int k = 1; k < NP; k++) begin
                n_tests++;
                if (hist[c][k] !== hist[c-S][k-1]) begin
                    n_fail++;
                    $display("FAIL lag phase%0d c=%0d got %0d want %0d",
                             k, c, hist[c][k], hist[c-S][k-1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        for (int j = 0; j < S + 1; j++) tick(1'b1, 1'b1);
        n_tests++;
        if (act_pos(1) !== 2) begin
            n_fail++;
            $display("FAIL reset_mid pre pos1 got %0d want 2", act_pos(1));
        end
        tick(1'b0, 1'b1);
        for (int k = 0; k < NP; k++) begin
            n_tests++;
            if (act_pos(k) !== 0 || act_neg(k) !== S || act_st(k) !== 0) begin
                n_fail++;
                $display("FAIL reset_mid phase%0d got pos=%0d neg=%0d st=%0d want 0/%0d/0",
                         k, act_pos(k), act_neg(k), act_st(k), S);
            end
        end
        tick(1'b1, 1'b0);
        n_tests++;
        if (busy !== 1'b0 || clkpos_lvl !== '0) begin
            n_fail++;
            $display("FAIL reset_mid idle got busy=%b pos=%h want 0/0", busy, clkpos_lvl);
        end
    endtask

    task automatic test_random();
        bit want = 1'b1;
        bit r;
        tick(1'b0, 1'b0);
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 19) == 0) want = ~want;
            r = ($urandom_range(0, 149) != 0);
            tick(r, want);
            for (int k = 0; k < NP; k++) begin
                n_tests++;
                if (act_pos(k) !== exp_pos[k] || act_neg(k) !== S - exp_pos[k] ||
                    act_st(k) !== exp_st[k]) begin
                    n_fail++;
                    $display("FAIL random c=%0d phase%0d got pos=%0d neg=%0d st=%0d want %0d/%0d/%0d",
                             c, k, act_pos(k), act_neg(k), act_st(k),
                             exp_pos[k], S - exp_pos[k], exp_st[k]);
                end
            end
            n_tests++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("FAIL random c=%0d busy got %b want %b", c, busy, exp_busy);
            end
        end
    endtask

`ifdef PCLK_CYCLE_CNT_EN
    task automatic test_cycle_cnt();
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        for (int c = 0; c < 12*S; c++) tick(1'b1, 1'b1);
        n_tests++;
        if (cycle_cnt !== 16'd3 || int'(cycle_cnt) !== m_cnt) begin
            n_fail++;
            $display("FAIL cycle_cnt three got %0d want 3", cycle_cnt);
        end
        dut.cnt_q = 16'hffff;
        m_cnt     = 65535;
        for (int c = 0; c < 4*S; c++) tick(1'b1, 1'b1);
        n_tests++;
        if (cycle_cnt !== 16'd0 || int'(cycle_cnt) !== m_cnt) begin
            n_fail++;
            $display("FAIL cycle_cnt wrap got %0d want 0", cycle_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_startup();
        test_drain();
        test_cancel();
        test_reset_mid();
        test_random();
`ifdef PCLK_CYCLE_CNT_EN
        test_cycle_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
